// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its word array.
package mem_pkg;

  localparam int MAX_LATENCY = 4;
  localparam int WORD_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } mem_port_t;

  // Copy of an accepted request; the core may change its inputs afterwards.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    mem_port_t   port;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, read-before-write, contents never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  // Enabled access: old word always appears on rdata, store commits alongside.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      if (we) begin
        mem[idx] <= wdata;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves fetch and data ports from one word array,
// one access in flight, round-robin on ties, LATENCY edges to response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instruction,
  output logic        i_valid,
  input  logic        d_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic        d_valid,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_LATENCY);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_latency_check
    $fatal(1, "mem_responder: LATENCY must be within 1..%0d", MAX_LATENCY);
  end

  mem_state_t            state;
  logic [CNT_W-1:0]      cnt;
  mem_port_t             last_grant;
  mem_port_t             grant;
  logic                  any_req;
  mem_req_t              req_q;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [WORD_W-1:0]     ram_rdata;
  logic [WORD_W-1:0]     instr_hold;
  logic [WORD_W-1:0]     rdata_hold;
  logic                  unused_addr_bits;

  // Arbiter: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    any_req = i_req | d_req;
    grant   = PORT_D;
    if (i_req && d_req) begin
      grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (i_req) begin
      grant = PORT_I;
    end
  end

  // The array is touched once, on the last BUSY edge; a reset before that
  // edge returns the FSM to IDLE so a pending store never lands.
  assign ram_en  = (state == BUSY) && (cnt == '0);
  assign ram_idx = req_q.addr[ADDR_WIDTH+1:2];

  // Byte offset and bits above the array depth do not select a word.
  assign unused_addr_bits = ^{req_q.addr[31:ADDR_WIDTH+2], req_q.addr[1:0]};

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (req_q.we),
    .idx  (ram_idx),
    .wdata(req_q.wdata),
    .rdata(ram_rdata)
  );

  // Request latch: capture the granted port's address/data at acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      req_q <= '{addr : (grant == PORT_I) ? instr_addr : data_addr,
                 wdata: write_data,
                 we   : (grant == PORT_D) && write_enable,
                 port : grant};
    end
  end

  // Control FSM with registered valid/busy outputs and grant history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= PORT_I;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            cnt        <= CNT_W'(LATENCY - 1);
            last_grant <= grant;
            busy       <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RESP;
            if (req_q.port == PORT_I) begin
              i_valid <= 1'b1;
            end else begin
              d_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          state   <= IDLE;
          i_valid <= 1'b0;
          d_valid <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          i_valid <= 1'b0;
          d_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Response holding registers: keep the last word each port received.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_hold <= '0;
      rdata_hold <= '0;
    end else if (state == RESP) begin
      if (i_valid) begin
        instr_hold <= ram_rdata;
      end
      if (d_valid && !req_q.we) begin
        rdata_hold <= ram_rdata;
      end
    end
  end

  // During the response cycle the RAM output register is presented directly;
  // otherwise the held word is shown. Store acks leave read_data untouched.
  assign instruction = i_valid ? ram_rdata : instr_hold;
  assign read_data   = (d_valid && !req_q.we) ? ram_rdata : rdata_hold;

endmodule
